// File: rtl/pwm_capture_ip.sv
// PWM capture: measures period and high time of an asynchronous PWM input, flags stuck input.
// Optional glitch filter enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture_ip #(
  parameter int unsigned           CNT_WIDTH      = 32,
  parameter int unsigned           SYNC_STAGES    = 2,
  parameter logic [CNT_WIDTH-1:0]  TIMEOUT_CYCLES = CNT_WIDTH'(1_000_000),
  parameter int unsigned           FILTER_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] period_cycles_o,
  output logic [CNT_WIDTH-1:0] high_cycles_o,
  output logic                 meas_valid,
  output logic                 stuck_o,
  output logic                 stuck_level_o
);

  if (SYNC_STAGES < 2 || FILTER_CYCLES < 1) begin : g_param_check
    $error("pwm_capture_ip: SYNC_STAGES must be >= 2 and FILTER_CYCLES >= 1");
  end

  typedef enum logic [1:0] {StIdle, StArm, StHigh, StLow} state_e;

  localparam logic [CNT_WIDTH-1:0] TimeoutLast = TIMEOUT_CYCLES - 1'b1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   w_level;
  logic                   r_prev;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_edge;
  logic                   w_timeout;

  state_e                 r_state, w_state_d;
  logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_d;
  logic [CNT_WIDTH-1:0]   r_hi_tmp, w_hi_tmp_d;
  logic [CNT_WIDTH-1:0]   r_idle, w_idle_d;
  logic [CNT_WIDTH-1:0]   r_period, w_period_d;
  logic [CNT_WIDTH-1:0]   r_high, w_high_d;
  logic                   r_valid, w_valid_d;
  logic                   r_stuck, w_stuck_d;
  logic                   r_stuck_lvl, w_stuck_lvl_d;
  logic [CNT_WIDTH-1:0]   w_cnt_inc;
  logic [CNT_WIDTH-1:0]   w_idle_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int unsigned FiltW = $clog2(FILTER_CYCLES + 1);

  logic [FiltW-1:0] r_filt_cnt;
  logic             r_filt;

  // New level must persist FILTER_CYCLES consecutive cycles before it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt     <= 1'b0;
      r_filt_cnt <= '0;
    end else if (w_sync == r_filt) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FiltW'(FILTER_CYCLES - 1)) begin
      r_filt     <= w_sync;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = w_sync;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign w_rise     = w_level & ~r_prev;
  assign w_fall     = ~w_level & r_prev;
  assign w_edge     = w_rise | w_fall;
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_idle_inc = (r_idle == '1) ? r_idle : r_idle + 1'b1;
  // An edge in the same cycle suppresses the timeout.
  assign w_timeout  = (TIMEOUT_CYCLES != '0) && (r_idle == TimeoutLast) && !w_edge;

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_hi_tmp_d    = r_hi_tmp;
    w_idle_d      = r_idle;
    w_period_d    = r_period;
    w_high_d      = r_high;
    w_valid_d     = 1'b0;
    w_stuck_d     = r_stuck;
    w_stuck_lvl_d = r_stuck_lvl;

    if (!enable) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
      w_idle_d  = '0;
      w_stuck_d = 1'b0;
    end else begin
      w_idle_d = w_edge ? '0 : w_idle_inc;
      if (w_edge) w_stuck_d = 1'b0;

      unique case (r_state)
        StIdle: begin
          w_state_d = StArm;
          w_cnt_d   = '0;
          w_idle_d  = '0;
        end
        StArm: begin
          if (w_rise) begin
            w_cnt_d   = CNT_WIDTH'(1);
            w_state_d = StHigh;
          end
        end
        StHigh: begin
          w_cnt_d = w_cnt_inc;
          if (w_fall) begin
            w_hi_tmp_d = r_cnt;
            w_state_d  = StLow;
          end
        end
        StLow: begin
          if (w_rise) begin
            w_period_d = r_cnt;
            w_high_d   = r_hi_tmp;
            w_valid_d  = 1'b1;
            w_cnt_d    = CNT_WIDTH'(1);
            w_state_d  = StHigh;
          end else begin
            w_cnt_d = w_cnt_inc;
          end
        end
        default: w_state_d = StIdle;
      endcase

      if (w_timeout && (r_state != StIdle)) begin
        w_stuck_d     = 1'b1;
        w_stuck_lvl_d = w_level;
        w_state_d     = StArm;
        w_cnt_d       = '0;
        w_idle_d      = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_hi_tmp    <= '0;
      r_idle      <= '0;
      r_period    <= '0;
      r_high      <= '0;
      r_valid     <= 1'b0;
      r_stuck     <= 1'b0;
      r_stuck_lvl <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_hi_tmp    <= w_hi_tmp_d;
      r_idle      <= w_idle_d;
      r_period    <= w_period_d;
      r_high      <= w_high_d;
      r_valid     <= w_valid_d;
      r_stuck     <= w_stuck_d;
      r_stuck_lvl <= w_stuck_lvl_d;
    end
  end

  assign period_cycles_o = r_period;
  assign high_cycles_o   = r_high;
  assign meas_valid      = r_valid;
  assign stuck_o         = r_stuck;
  assign stuck_level_o   = r_stuck_lvl;

endmodule

// File: tb/tb_pwm_capture_ip.sv
// Self-checking bench for pwm_capture_ip: table-driven PWM periods with a result scoreboard,
// plus hand-written enable, timeout, reset and glitch sequences.
module tb_pwm_capture_ip;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        enable = 1'b0;
  logic        pwm_in = 1'b0;
  logic [31:0] period_cycles_o;
  logic [31:0] high_cycles_o;
  logic        meas_valid;
  logic        stuck_o;
  logic        stuck_level_o;

  pwm_capture_ip #(
    .CNT_WIDTH      (32),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (32'd1000),
    .FILTER_CYCLES  (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .pwm_in          (pwm_in),
    .period_cycles_o (period_cycles_o),
    .high_cycles_o   (high_cycles_o),
    .meas_valid      (meas_valid),
    .stuck_o         (stuck_o),
    .stuck_level_o   (stuck_level_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned hi;
    int unsigned lo;
    int unsigned exp_per;
    int unsigned exp_hi;
  } vec_t;

  typedef struct {
    logic [31:0] per;
    logic [31:0] hi;
  } res_t;

  res_t sb_q[$];
  res_t prev;
  bit   prev_valid = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_meas  = 0;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Every published result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    res_t e;
    if (rst_n && meas_valid === 1'b1) begin
      n_meas++;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_meas_valid: got period %0d high %0d, expected no result",
                 period_cycles_o, high_cycles_o);
      end else begin
        e = sb_q.pop_front();
        chk("period", period_cycles_o, e.per);
        chk("high", high_cycles_o, e.hi);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rise();
    if (prev_valid) sb_q.push_back(prev);
    pwm_in = 1'b1;
  endtask

  task automatic pwm_period(input int hi, input int lo, input int per, input int h);
    rise();
    tick(hi);
    pwm_in = 1'b0;
    tick(lo);
    prev.per   = 32'(per);
    prev.hi    = 32'(h);
    prev_valid = 1'b1;
  endtask

  task automatic drain(input string name);
    tick(12);
    chk(name, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, period_cycles_o, 32'd0);
    chk({tag, "_high"}, high_cycles_o, 32'd0);
    chk({tag, "_valid"}, 32'(meas_valid), 32'd0);
    chk({tag, "_stuck"}, 32'(stuck_o), 32'd0);
    chk({tag, "_stuck_level"}, 32'(stuck_level_o), 32'd0);
  endtask

  initial begin
    int k;
    tbl[0] = '{25, 75, 100, 25};
    tbl[1] = '{25, 75, 100, 25};
    tbl[2] = '{25, 75, 100, 25};
    tbl[3] = '{25, 75, 100, 25};
    tbl[4] = '{10, 30, 40, 10};
    tbl[5] = '{10, 30, 40, 10};
    tbl[6] = '{10, 30, 40, 10};

    #1 rst_n = 1'b0;
    tick(2);
    chk_zero("reset");
    rst_n = 1'b1;
    tick(2);
    enable = 1'b1;
    tick(3);

    // Steady 25% then a period change; first rise after arming publishes nothing.
    for (int i = 0; i < 7; i++) pwm_period(tbl[i].hi, tbl[i].lo, tbl[i].exp_per, tbl[i].exp_hi);
    rise();
    drain("drain_table");
    chk("meas_count_table", 32'(n_meas), 32'd7);

    // Enable dropped mid-HIGH: results hold; re-arm needs a fresh rise plus a full period.
    enable = 1'b0;
    tick(4);
    chk("idle_hold_period", period_cycles_o, 32'd40);
    chk("idle_hold_high", high_cycles_o, 32'd10);
    chk("idle_stuck", 32'(stuck_o), 32'd0);
    enable = 1'b1;
    prev_valid = 1'b0;
    tick(4);
    pwm_in = 1'b0;
    tick(30);
    pwm_period(20, 60, 80, 20);
    pwm_period(20, 60, 80, 20);

    // Held high: stuck exactly 1000 cycles after the last edge takes effect.
    rise();
    k = 0;
    while (meas_valid !== 1'b1 && k < 20) begin
      tick(1);
      k++;
    end
    k = 0;
    do begin
      tick(1);
      k++;
    end while (stuck_o !== 1'b1 && k < 1100);
    chk("stuck_delay", 32'(k), 32'd1000);
    chk("stuck_level", 32'(stuck_level_o), 32'd1);
    chk("meas_count_pre_stuck", 32'(n_meas), 32'd9);
    pwm_in = 1'b0;
    k = 0;
    while (stuck_o !== 1'b0 && k < 20) begin
      tick(1);
      k++;
    end
    chk("stuck_clear", 32'(stuck_o), 32'd0);
    tick(5);
    chk("meas_count_post_stuck", 32'(n_meas), 32'd9);
    chk("stuck_hold_period", period_cycles_o, 32'd80);
    prev_valid = 1'b0;

    // Asynchronous reset during LOW.
    pwm_period(25, 75, 100, 25);
    pwm_period(25, 75, 100, 25);
    rise();
    tick(25);
    pwm_in = 1'b0;
    drain("drain_pre_reset");
    tick(20);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    prev_valid = 1'b0;
    tick(2);
    pwm_period(25, 75, 100, 25);
    pwm_period(25, 75, 100, 25);
    pwm_period(25, 75, 100, 25);

    // Two-cycle glitch inside the low phase.
    rise();
    tick(25);
    pwm_in = 1'b0;
    tick(30);
`ifndef PWM_CAPTURE_FILTER_EN
    sb_q.push_back('{per: 32'd55, hi: 32'd25});
`endif
    pwm_in = 1'b1;
    tick(2);
    pwm_in = 1'b0;
    tick(43);
`ifdef PWM_CAPTURE_FILTER_EN
    sb_q.push_back('{per: 32'd100, hi: 32'd25});
`else
    sb_q.push_back('{per: 32'd45, hi: 32'd2});
`endif
    pwm_in = 1'b1;
    tick(25);
    pwm_in = 1'b0;
    tick(20);
    drain("drain_glitch");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
